// File: rtl/apb_master_bridge.sv
// -----------------------------------------------------------------------------
// apb_master_bridge
//
// Initiator end of the SoC peripheral APB bus. Converts a req/gnt/rvalid
// load-store port into APB SETUP/ACCESS transfers. Partial writes are
// rejected without touching the bus. An ACCESS-phase timeout keeps a hung
// slave from stalling the core.
//
// Ports
//   clk_i, rst_ni          clock, synchronous active-low reset
//   req_i/addr_i/we_i/     core-side request; gnt_o accepts it (IDLE only)
//   wdata_i/be_i/gnt_o
//   rvalid_o/rdata_o/      one-cycle response with read data and error flag
//   err_o
//   paddr_o/pwdata_o/      APB master outputs
//   pwrite_o/psel_o/
//   penable_o
//   prdata_i/pready_i/     APB slave response
//   pslverr_i
//
// States
//   IDLE   | waiting for a request; gnt_o follows req_i
//   SETUP  | APB setup phase (psel=1, penable=0)
//   ACCESS | APB access phase, waiting for pready or timeout
//   RESP   | rvalid_o pulse with captured rdata/err
// -----------------------------------------------------------------------------
module apb_master_bridge #(
    parameter int unsigned APB_ADDR_WIDTH = 32,
    parameter int unsigned APB_DATA_WIDTH = 32,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        req_i,
    input  logic [APB_ADDR_WIDTH-1:0]   addr_i,
    input  logic                        we_i,
    input  logic [APB_DATA_WIDTH-1:0]   wdata_i,
    input  logic [APB_DATA_WIDTH/8-1:0] be_i,
    output logic                        gnt_o,
    output logic                        rvalid_o,
    output logic [APB_DATA_WIDTH-1:0]   rdata_o,
    output logic                        err_o,
    output logic [APB_ADDR_WIDTH-1:0]   paddr_o,
    output logic [APB_DATA_WIDTH-1:0]   pwdata_o,
    output logic                        pwrite_o,
    output logic                        psel_o,
    output logic                        penable_o,
    input  logic [APB_DATA_WIDTH-1:0]   prdata_i,
    input  logic                        pready_i,
    input  logic                        pslverr_i
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT_CYCLES > 1) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;
    localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_e;

    state_e                      state_q, state_d;
    logic [APB_ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic                        we_q, we_d;
    logic [APB_DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [APB_DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic                        err_q, err_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;

    logic bus_active;
    logic timeout_hit;

    assign bus_active  = (state_q == SETUP) || (state_q == ACCESS);
    assign timeout_hit = TIMEOUT_EN && (cnt_q == CNT_LAST);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        cnt_d   = '0;

        unique case (state_q)
            IDLE: begin
                if (req_i) begin
                    addr_d  = addr_i;
                    we_d    = we_i;
                    wdata_d = wdata_i;
                    // Sub-word writes are refused without a bus cycle.
                    if (we_i && (be_i != '1)) begin
                        state_d = RESP;
                        rdata_d = '0;
                        err_d   = 1'b1;
                    end else begin
                        state_d = SETUP;
                    end
                end
            end
            SETUP: begin
                state_d = ACCESS;
            end
            ACCESS: begin
                // A completing slave takes priority over the timeout.
                if (pready_i) begin
                    state_d = RESP;
                    rdata_d = we_q ? '0 : prdata_i;
                    err_d   = pslverr_i;
                end else if (timeout_hit) begin
                    state_d = RESP;
                    rdata_d = '0;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign gnt_o     = (state_q == IDLE) && req_i;
    assign rvalid_o  = (state_q == RESP);
    assign rdata_o   = (state_q == RESP) ? rdata_q : '0;
    assign err_o     = (state_q == RESP) && err_q;

    assign psel_o    = bus_active;
    assign penable_o = (state_q == ACCESS);
    assign paddr_o   = bus_active ? {addr_q[APB_ADDR_WIDTH-1:2], 2'b00} : '0;
    assign pwrite_o  = bus_active && we_q;
    assign pwdata_o  = (bus_active && we_q) ? wdata_q : '0;

endmodule

// File: tb/tb_apb_master_bridge.sv
module tb_apb_master_bridge;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } resp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        gnt, rvalid, err, pwrite, psel, penable;
    logic [31:0] rdata, paddr, pwdata;
    logic [31:0] prdata;
    logic        pready, pslverr;

    int    checks = 0;
    int    errors = 0;
    resp_t sb_q[$];

    apb_master_bridge #(
        .APB_ADDR_WIDTH(32),
        .APB_DATA_WIDTH(32),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .req_i    (req),
        .addr_i   (addr),
        .we_i     (we),
        .wdata_i  (wdata),
        .be_i     (be),
        .gnt_o    (gnt),
        .rvalid_o (rvalid),
        .rdata_o  (rdata),
        .err_o    (err),
        .paddr_o  (paddr),
        .pwdata_o (pwdata),
        .pwrite_o (pwrite),
        .psel_o   (psel),
        .penable_o(penable),
        .prdata_i (prdata),
        .pready_i (pready),
        .pslverr_i(pslverr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge, where inputs are driven.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle after driving inputs.
    task automatic settle();
        #2;
    endtask

    task automatic chk_resp(input string tag);
        resp_t e;
        chk({tag, "_rvalid"}, 64'(rvalid), 64'd1);
        if (sb_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 64'(sb_q.size()), 64'd1);
        end else begin
            e = sb_q.pop_front();
            chk({tag, "_rdata"}, 64'(rdata), 64'(e.rdata));
            chk({tag, "_err"}, 64'(err), 64'(e.err));
        end
    endtask

    task automatic issue(input logic [31:0] a, input logic w, input logic [31:0] d,
                         input logic [3:0] b, input logic [31:0] exp_rd, input logic exp_err);
        req   = 1'b1;
        addr  = a;
        we    = w;
        wdata = d;
        be    = b;
        sb_q.push_back('{rdata: exp_rd, err: exp_err});
    endtask

    task automatic idle_inputs();
        req     = 1'b0;
        addr    = 32'h0;
        we      = 1'b0;
        wdata   = 32'h0;
        be      = 4'h0;
    endtask

    // Zero-wait read from c0 through c3.
    task automatic zw_read(input string tag, input logic [31:0] a, input logic [31:0] d);
        issue(a, 1'b0, 32'h0, 4'h0, d, 1'b0);
        settle();
        chk({tag, "_gnt"}, 64'(gnt), 64'd1);
        step(); idle_inputs(); settle();
        chk({tag, "_setup"}, {psel, penable}, 64'b10);
        chk({tag, "_paddr_s"}, 64'(paddr), 64'({a[31:2], 2'b00}));
        step(); pready = 1'b1; prdata = d; settle();
        chk({tag, "_access"}, {psel, penable, pwrite}, 64'b110);
        step(); pready = 1'b0; prdata = 32'h0; settle();
        chk_resp(tag);
        chk({tag, "_psel_resp"}, 64'(psel), 64'd0);
    endtask

    initial begin
        rst_n   = 1'b0;
        pready  = 1'b0;
        prdata  = 32'h0;
        pslverr = 1'b0;
        idle_inputs();
        repeat (3) step();
        settle();
        chk("reset_outs", {gnt, rvalid, err, pwrite, psel, penable},   64'd0);
        chk("reset_data", {rdata, paddr},                               64'd0);
        chk("reset_pwdata", 64'(pwdata),                                64'd0);
        rst_n = 1'b1;

        // Zero-wait read, be ignored.
        step();
        zw_read("rd0", 32'h4A10_3004, 32'h1234_5678);
        step(); settle();
        chk("rd0_rvalid_once", 64'(rvalid), 64'd0);

        // Write with 3 wait states; pslverr noise outside pready ignored.
        issue(32'h4A10_1000, 1'b1, 32'hA5A5_0F0F, 4'hF, 32'h0, 1'b0);
        settle();
        chk("wr_gnt", 64'(gnt), 64'd1);
        step(); idle_inputs(); settle();
        chk("wr_setup", {psel, penable, pwrite}, 64'b101);
        for (int i = 0; i < 4; i++) begin
            step();
            pready  = (i == 3);
            pslverr = (i != 3);
            prdata  = 32'hDEAD_BEEF;
            settle();
            chk($sformatf("wr_access%0d", i), {psel, penable, pwrite}, 64'b111);
            chk($sformatf("wr_pwdata%0d", i), 64'(pwdata), 64'hA5A5_0F0F);
            chk($sformatf("wr_paddr%0d", i), 64'(paddr), 64'h4A10_1000);
        end
        step(); pready = 1'b0; pslverr = 1'b0; prdata = 32'h0; settle();
        chk_resp("wr");
        chk("wr_bus_idle", {pwrite, psel, penable}, 64'd0);
        chk("wr_pwdata_idle", 64'(pwdata), 64'd0);

        // Partial write rejected without a bus cycle.
        step();
        issue(32'h4A10_1004, 1'b1, 32'h1111_2222, 4'h3, 32'h0, 1'b1);
        settle();
        chk("pw_gnt", 64'(gnt), 64'd1);
        step(); idle_inputs(); settle();
        chk("pw_no_psel", 64'(psel), 64'd0);
        chk_resp("pw");
        step(); settle();
        chk("pw_done", {rvalid, psel}, 64'd0);

        // Slave error on a read; unaligned address.
        issue(32'h4A10_2007, 1'b0, 32'h0, 4'hF, 32'hCAFE_0001, 1'b1);
        settle();
        step(); idle_inputs(); settle();
        chk("se_paddr", 64'(paddr), 64'h4A10_2004);
        chk("se_pwdata_rd", 64'(pwdata), 64'd0);
        step(); pready = 1'b1; pslverr = 1'b1; prdata = 32'hCAFE_0001; settle();
        step(); pready = 1'b0; pslverr = 1'b0; prdata = 32'h0; settle();
        chk_resp("se");

        // Timeout: penable for exactly 8 cycles.
        step();
        issue(32'h4A10_5000, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1);
        settle();
        step(); idle_inputs(); prdata = 32'h7777_7777; settle();
        for (int i = 0; i < 8; i++) begin
            step(); settle();
            chk($sformatf("to_penable%0d", i), {psel, penable, rvalid}, 64'b110);
        end
        step(); settle();
        chk("to_psel_drop", {psel, penable}, 64'd0);
        chk_resp("to");
        prdata = 32'h0;

        // pready on the expiry cycle wins.
        step();
        issue(32'h4A10_5004, 1'b0, 32'h0, 4'h0, 32'h0BAD_F00D, 1'b0);
        settle();
        step(); idle_inputs(); settle();
        for (int i = 0; i < 8; i++) begin
            step();
            pready = (i == 7);
            prdata = 32'h0BAD_F00D;
            settle();
        end
        chk("tw_last_access", {psel, penable}, 64'b11);
        step(); pready = 1'b0; prdata = 32'h0; settle();
        chk_resp("tw");

        // Normal read after timeout.
        step();
        zw_read("rd1", 32'h4A10_6008, 32'h89AB_CDEF);

        // Reset mid-ACCESS abandons the transfer.
        step();
        issue(32'h4A10_7000, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0);
        settle();
        step(); idle_inputs(); settle();
        step(); settle();
        chk("rst_in_access", 64'(penable), 64'd1);
        step(); rst_n = 1'b0; settle();
        step(); rst_n = 1'b1; settle();
        void'(sb_q.pop_back());
        chk("rst_bus", {psel, penable, rvalid, err, pwrite}, 64'd0);
        chk("rst_paddr", 64'(paddr), 64'd0);
        step(); settle();
        chk("rst_no_rvalid", 64'(rvalid), 64'd0);
        zw_read("rd2", 32'h4A10_7010, 32'h0F0F_F0F0);

        // req held high: grants only in IDLE.
        step();
        issue(32'h4A10_8000, 1'b0, 32'h0, 4'h0, 32'h5555_AAAA, 1'b0);
        settle();
        chk("hold_gnt_c0", 64'(gnt), 64'd1);
        step(); settle();
        chk("hold_gnt_c1", 64'(gnt), 64'd0);
        step(); pready = 1'b1; prdata = 32'h5555_AAAA; settle();
        chk("hold_gnt_c2", 64'(gnt), 64'd0);
        step(); pready = 1'b0; prdata = 32'h0; settle();
        chk("hold_gnt_c3", 64'(gnt), 64'd0);
        chk_resp("hold");
        sb_q.push_back('{rdata: 32'h5555_AAAA, err: 1'b0});
        step(); settle();
        chk("hold_gnt_c4", 64'(gnt), 64'd1);
        step(); idle_inputs(); settle();
        step(); pready = 1'b1; prdata = 32'h5555_AAAA; settle();
        step(); pready = 1'b0; prdata = 32'h0; settle();
        chk_resp("hold2");

        chk("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
